// File: rtl/serial_addsub_seq.sv
// Bit-serial WIDTH-bit add/subtract: one LSB-first bit pair per clock through a 1-bit full adder/subtractor slice.
// Latency: start sampled at edge k, done pulses in the cycle after edge k+WIDTH; busy is high for WIDTH cycles.
// Backpressure: none; start is accepted only in IDLE or DONE and ignored while busy.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, op, a, b   request, 0=add/1=sub, operands (sampled together with start)
//   busy, done        processing indicator, one-cycle completion pulse
//   result, cout, ovf sum/difference mod 2^WIDTH, carry/borrow out of MSB, signed overflow
module serial_addsub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             op_r;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             x;
  logic             y;
  logic             s;
  logic             cn;
  logic [WIDTH-1:0] acc_nxt;

  // The single arithmetic slice. Sum and difference bits share the same XOR;
  // only the carry/borrow generation differs.
  always_comb begin
    x       = a_sr[0];
    y       = b_sr[0];
    s       = x ^ y ^ c;
    cn      = op_r ? ((~x & y) | (~(x ^ y) & c))
                   : ((x & y) | (x & c) | (y & c));
    // Right-shifting into the MSB leaves bit 0 in position 0 after WIDTH shifts.
    acc_nxt = {s, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      acc    <= '0;
      op_r   <= 1'b0;
      c      <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            op_r  <= op;
            c     <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          acc  <= acc_nxt;
          c    <= cn;
          if (cnt == LAST) begin
            // c is the carry/borrow into the MSB here, cn the one out of it.
            result <= acc_nxt;
            cout   <= cn;
            ovf    <= c ^ cn;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Directed self-checking bench for serial_addsub_seq (WIDTH=8).
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_serial_addsub_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       ovf;

  int errors = 0;
  int checks = 0;

  int         busy_n;
  int         done_n;
  int         done_at;
  logic       first_busy;
  logic [7:0] res_d;
  logic       cout_d;
  logic       ovf_d;
  logic       seen_done;

  serial_addsub_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  // Follows one operation from its start edge. Optionally pulses a stray
  // start during RUN, or chains the next op by asserting start in the done cycle.
  task automatic track(input int pulse_at, input bit chain,
                       input logic nop, input logic [7:0] na, input logic [7:0] nb);
    busy_n = 0; done_n = 0; done_at = 0; first_busy = 1'b0;
    @(posedge clk);
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 1) first_busy = busy;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) begin
          done_at = i; res_d = result; cout_d = cout; ovf_d = ovf;
        end
        if (chain) begin
          start = 1'b1; op = nop; a = na; b = nb;
          return;
        end
      end
      if (i == pulse_at) begin
        start = 1'b1; op = 1'b1; a = 8'hAA; b = 8'h55;
      end
    end
  endtask

  task automatic check_op(input string tag, input logic [7:0] er, input logic ec, input logic eo);
    chk({tag, ".busy_first"}, 32'(first_busy), 32'd1);
    chk({tag, ".busy_cycles"}, busy_n, 32'd8);
    chk({tag, ".done_pulses"}, done_n, 32'd1);
    chk({tag, ".done_cycle"}, done_at, 32'd9);
    chk({tag, ".result"}, 32'(res_d), 32'(er));
    chk({tag, ".cout"}, 32'(cout_d), 32'(ec));
    chk({tag, ".ovf"}, 32'(ovf_d), 32'(eo));
    chk({tag, ".result_hold"}, 32'(result), 32'(er));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.result", 32'(result), 32'd0);
    chk("rst.cout", 32'(cout), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle.busy", 32'(busy), 32'd0);

    issue(1'b0, 8'h3C, 8'h5A); track(0, 1'b0, 1'b0, 8'h00, 8'h00); check_op("add_3c_5a", 8'h96, 1'b1 ^ 1'b1, 1'b1);
    issue(1'b0, 8'hFF, 8'h01); track(0, 1'b0, 1'b0, 8'h00, 8'h00); check_op("add_ff_01", 8'h00, 1'b1, 1'b0);
    issue(1'b0, 8'h00, 8'h00); track(0, 1'b0, 1'b0, 8'h00, 8'h00); check_op("add_00_00", 8'h00, 1'b0, 1'b0);
    issue(1'b1, 8'h10, 8'h20); track(0, 1'b0, 1'b0, 8'h00, 8'h00); check_op("sub_10_20", 8'hF0, 1'b1, 1'b0);

    // Stray start in RUN cycle 3 must be ignored
    issue(1'b0, 8'h01, 8'h01); track(3, 1'b0, 1'b0, 8'h00, 8'h00); check_op("add_ignore", 8'h02, 1'b0, 1'b0);

    // Back-to-back: start asserted in the done cycle
    issue(1'b0, 8'h01, 8'h02); track(0, 1'b1, 1'b1, 8'h05, 8'h03); check_op("b2b_first", 8'h03, 1'b0, 1'b0);
    track(0, 1'b0, 1'b0, 8'h00, 8'h00); check_op("b2b_sub_05_03", 8'h02, 1'b0, 1'b0);

    issue(1'b1, 8'h80, 8'h01); track(0, 1'b0, 1'b0, 8'h00, 8'h00); check_op("sub_80_01", 8'h7F, 1'b0, 1'b1);

    // Asynchronous reset with counter at bit 4 of an add
    issue(1'b0, 8'h7F, 8'h01);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    chk("arst.result", 32'(result), 32'd0);
    chk("arst.cout", 32'(cout), 32'd0);
    chk("arst.ovf", 32'(ovf), 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("arst.no_done", 32'(seen_done), 32'd0);
    chk("arst.idle_busy", 32'(busy), 32'd0);
    chk("arst.idle_result", 32'(result), 32'd0);

    issue(1'b0, 8'h7F, 8'h01); track(0, 1'b0, 1'b0, 8'h00, 8'h00); check_op("add_7f_01", 8'h80, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_addsub_seq.md
Name: serial_addsub_seq

Overview:
Bit-serial add/subtract sequencer sitting directly upstream of the full adder/subtractor cell. It latches two WIDTH-bit operands and feeds one LSB-first bit pair per clock through full-adder or full-subtractor logic. It keeps the carry or borrow in a flop between bits and assembles the result. It trades WIDTH cycles of latency for a single 1-bit arithmetic slice. The start/busy/done handshake is consumed by the datapath controller.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE or DONE.
op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
a  input  WIDTH  operand A / minuend; sampled with start.
b  input  WIDTH  operand B / subtrahend; sampled with start.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse; result/cout/ovf are valid from this cycle.
result  output  WIDTH  (a+b) or (a-b) mod 2^WIDTH.
cout  output  1  add: carry out of MSB; sub: borrow out of MSB (1 iff a < b unsigned).
ovf  output  1  signed two's-complement overflow of the completed operation.

Behaviour:
- Clock and reset: single clock (clk); reset (rst) is asynchronous, active-high.
- Reset: state=IDLE. busy, done, result, cout, ovf, internal shift registers, bit counter and carry flop are all 0. Reset asserted mid-operation aborts the operation immediately. No done is produced. Outputs read 0 until the next completed operation.
- States: IDLE, RUN, DONE.
  - IDLE: on start=1, latch a, b, op into shift registers, clear the carry/borrow flop and counter, go to RUN.
  - RUN: busy=1. Each edge processes bit i=counter: x=a_sr[0], y=b_sr[0], c=carry flop.
    - Add: s = x^y^c; c' = (x&y)|(x&c)|(y&c).
    - Sub: s = x^y^c; c' = (~x&y)|(~(x^y)&c).
    - Shift a_sr and b_sr right by 1. Shift s into the MSB of the internal accumulator (right shift), so bit 0 lands in position 0 after WIDTH shifts. Carry flop <= c'. Counter++.
    - On the edge processing bit WIDTH-1: result <= final accumulator, cout <= c'. ovf <= (c at MSB) XOR c'. This equals carry-in-to-MSB xor carry-out for add, and borrow-in-to-MSB xor borrow-out for sub. done <= 1, state -> DONE.
  - DONE: busy=0, done=1 for exactly this cycle. On start=1, latch the new operands and go to RUN (back-to-back, no idle gap). Otherwise go to IDLE.
- Latency: start sampled at edge k; done is high in the cycle following edge k+WIDTH; busy is high for exactly WIDTH cycles.
- start while in RUN is ignored. Operand and op changes while busy have no effect.
- result, cout and ovf change only on the done edge (or reset) and hold their values otherwise.
- Counter width is clog2(WIDTH) bits and does not wrap during an operation.

Test Plan:
- WIDTH=8, add, a=0x3C, b=0x5A -> done exactly 9 cycles after the start edge. result=0x96, cout=0, ovf=1. busy high for 8 cycles.
- Add, a=0xFF, b=0x01 -> result=0x00, cout=1, ovf=0. Add, a=0x00, b=0x00 -> result=0x00, cout=0, ovf=0.
- Sub, a=0x10, b=0x20 -> result=0xF0, cout(borrow)=1, ovf=0. Sub, a=0x80, b=0x01 -> result=0x7F, cout=0, ovf=1.
- Start an add 0x01+0x01, pulse start with a=0xAA, b=0x55, op=1 during cycle 3 of RUN. Require the pulse to be ignored: result=0x02, done pulses once, no second operation.
- Assert start in the DONE cycle with sub 0x05-0x03. Require busy to rise on the next cycle with no idle gap, result=0x02, cout=0, ovf=0.
- Assert rst asynchronously (mid-cycle) at bit 4 of an add 0x7F+0x01. Require all outputs to go to 0 immediately and done never to pulse. After release, a new op 0x7F+0x01 gives result=0x80, cout=0, ovf=1.
